// File: rtl/led_pattern_sequencer.sv
// Debounced switch bank driving an 8-LED display: pass-through, up/down counter,
// rotate and bounce patterns, stepped by a switch-selectable prescaled tick.
module led_pattern_sequencer #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned TICK_DIV        = 1600000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] switches,
  output logic [7:0] leds,
  output logic [1:0] mode,
  output logic       tick
);

  localparam int unsigned   CW       = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned   PW       = $clog2(TICK_DIV) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    PASS   = 2'b00,
    COUNT  = 2'b01,
    SHIFT  = 2'b10,
    BOUNCE = 2'b11
  } state_e;

  logic [7:0]    s1_q;
  logic [7:0]    s2_q;
  logic [7:0]    cand_q;
  logic [7:0]    sw_db_q;
  logic [CW-1:0] cnt_q;

  state_e        state_q;
  state_e        mode_d;
  logic [3:0]    fld_q;
  logic [PW-1:0] presc_q;
  logic [PW-1:0] period_d;
  logic          tick_q;
  logic [7:0]    pattern_q;
  logic [7:0]    leds_q;
  logic [7:0]    count_d;
  logic [7:0]    rot_d;
  logic [2:0]    pos_q;
  logic [2:0]    pos_d;
  logic          up_q;

  logic          fld_chg;
  logic          entry;
  logic          term;
  logic          step;

  // Two-flop synchroniser feeding a whole-vector stability filter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_q    <= '0;
      s2_q    <= '0;
      cand_q  <= '0;
      cnt_q   <= '0;
      sw_db_q <= '0;
    end else begin
      s1_q <= switches;
      s2_q <= s1_q;
      if (s2_q != cand_q) begin
        cand_q <= s2_q;
        cnt_q  <= '0;
      end else if (cnt_q != CNT_LAST) begin
        cnt_q <= cnt_q + 1'b1;
      end else begin
        sw_db_q <= cand_q;
      end
    end
  end

  always_comb begin
    mode_d   = state_e'(sw_db_q[7:6]);
    period_d = PW'(TICK_DIV >> sw_db_q[5:4]);
    fld_chg  = (sw_db_q[7:4] != fld_q);
    entry    = (mode_d != state_q);
    term     = (presc_q == (period_d - 1'b1));
    step     = term && !fld_chg;
    count_d  = sw_db_q[0] ? (pattern_q - 8'd1) : (pattern_q + 8'd1);
    rot_d    = {pattern_q[6:0], pattern_q[7]};
    pos_d    = up_q ? (pos_q + 3'd1) : (pos_q - 3'd1);
  end

  // Mode/speed changes are seen one edge after sw_db moves; that same edge
  // restarts the prescaler and performs the entry load, so the two never overlap.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= PASS;
      fld_q     <= '0;
      presc_q   <= '0;
      tick_q    <= 1'b0;
      pattern_q <= '0;
      pos_q     <= '0;
      up_q      <= 1'b1;
      leds_q    <= '0;
    end else begin
      state_q <= mode_d;
      tick_q  <= step;

      if (fld_chg) begin
        fld_q   <= sw_db_q[7:4];
        presc_q <= '0;
      end else if (term) begin
        presc_q <= '0;
      end else begin
        presc_q <= presc_q + 1'b1;
      end

      unique case (mode_d)
        PASS: begin
          leds_q <= {2'b00, sw_db_q[5:0]};
        end
        COUNT: begin
          if (entry) begin
            pattern_q <= 8'h00;
            leds_q    <= 8'h00;
          end else if (step) begin
            pattern_q <= count_d;
            leds_q    <= count_d;
          end
        end
        SHIFT: begin
          if (entry) begin
            pattern_q <= 8'h01;
            leds_q    <= 8'h01;
          end else if (step) begin
            pattern_q <= rot_d;
            leds_q    <= rot_d;
          end
        end
        BOUNCE: begin
          if (entry) begin
            pos_q  <= '0;
            up_q   <= 1'b1;
            leds_q <= 8'h01;
          end else if (step) begin
            pos_q  <= pos_d;
            leds_q <= 8'h01 << pos_d;
            // Flip direction on arrival so each end is lit for a single tick.
            if (pos_d == 3'd7) begin
              up_q <= 1'b0;
            end else if (pos_d == 3'd0) begin
              up_q <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign leds = leds_q;
  assign mode = sw_db_q[7:6];
  assign tick = tick_q;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Scoreboard bench for led_pattern_sequencer: expected LED values and tick
// spacing are queued when switches are driven and checked at each tick.
module tb_led_pattern_sequencer;

  logic       clk      = 1'b0;
  logic       rst      = 1'b0;
  logic [7:0] switches = 8'hFF;
  logic [7:0] leds;
  logic [1:0] mode;
  logic       tick;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] exp_q[$];
  int         gap_q[$];

  led_pattern_sequencer #(
    .DEBOUNCE_CYCLES(4),
    .TICK_DIV       (8)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .switches(switches),
    .leds    (leds),
    .mode    (mode),
    .tick    (tick)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_tick(input int limit, output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (tick !== 1'b1 && n < limit);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    switches = 8'hFF;
    cycles(2);
    n_cmp++; if (leds !== 8'h00) begin n_bad++; $display("FAIL reset_leds: got %h want 00", leds); end
    n_cmp++; if (mode !== 2'b00) begin n_bad++; $display("FAIL reset_mode: got %b want 00", mode); end
    n_cmp++; if (tick !== 1'b0)  begin n_bad++; $display("FAIL reset_tick: got %b want 0", tick); end
    rst = 1'b1;
    switches = 8'h3F;
    cycles(7);
    n_cmp++; if (leds !== 8'h00) begin n_bad++; $display("FAIL release_early: got %h want 00", leds); end
    cycles(1);
    n_cmp++; if (leds !== 8'h3F) begin n_bad++; $display("FAIL release_leds: got %h want 3F", leds); end
    n_cmp++; if (mode !== 2'b00) begin n_bad++; $display("FAIL release_mode: got %b want 00", mode); end
  endtask

  task automatic test_pass();
    int dev;
    switches = 8'h2A;
    cycles(7);
    n_cmp++; if (leds !== 8'h3F) begin n_bad++; $display("FAIL pass_early: got %h want 3F", leds); end
    cycles(1);
    n_cmp++; if (leds !== 8'h2A) begin n_bad++; $display("FAIL pass_leds: got %h want 2A", leds); end
    switches = 8'h15;
    cycles(3);
    switches = 8'h2A;
    dev = 0;
    for (int i = 0; i < 12; i++) begin
      cycles(1);
      if (leds !== 8'h2A) dev++;
    end
    n_cmp++; if (dev != 0) begin n_bad++; $display("FAIL pass_glitch: leds left 2A on %0d clocks, want 0", dev); end
  endtask

  task automatic test_count();
    logic [7:0] e;
    int g, n;
    switches = 8'h40;
    cycles(8);
    n_cmp++; if (leds !== 8'h00) begin n_bad++; $display("FAIL count_entry: got %h want 00", leds); end
    n_cmp++; if (mode !== 2'b01) begin n_bad++; $display("FAIL count_mode: got %b want 01", mode); end
    exp_q.push_back(8'h01); gap_q.push_back(8);
    exp_q.push_back(8'h02); gap_q.push_back(8);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = gap_q.pop_front();
      wait_tick(g + 4, n);
      n_cmp++; if (n !== g)    begin n_bad++; $display("FAIL count_gap: got %0d clocks want %0d", n, g); end
      n_cmp++; if (leds !== e) begin n_bad++; $display("FAIL count_up: got %h want %h", leds, e); end
    end
    switches = 8'h41;
    cycles(1);
    n_cmp++; if (tick !== 1'b0) begin n_bad++; $display("FAIL tick_pulse: got %b want 0", tick); end
    exp_q.push_back(8'h01); gap_q.push_back(7);
    exp_q.push_back(8'h00); gap_q.push_back(8);
    exp_q.push_back(8'hFF); gap_q.push_back(8);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = gap_q.pop_front();
      wait_tick(g + 4, n);
      n_cmp++; if (n !== g)    begin n_bad++; $display("FAIL count_down_gap: got %0d clocks want %0d", n, g); end
      n_cmp++; if (leds !== e) begin n_bad++; $display("FAIL count_down: got %h want %h", leds, e); end
    end
  endtask

  task automatic test_shift();
    logic [7:0] e;
    int g, n;
    switches = 8'h90;
    cycles(8);
    n_cmp++; if (leds !== 8'h01) begin n_bad++; $display("FAIL shift_entry: got %h want 01", leds); end
    n_cmp++; if (mode !== 2'b10) begin n_bad++; $display("FAIL shift_mode: got %b want 10", mode); end
    n_cmp++; if (tick !== 1'b0)  begin n_bad++; $display("FAIL shift_entry_tick: got %b want 0", tick); end
    e = 8'h01;
    for (int i = 0; i < 8; i++) begin
      e = {e[6:0], e[7]};
      exp_q.push_back(e); gap_q.push_back(4);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = gap_q.pop_front();
      wait_tick(g + 4, n);
      n_cmp++; if (n !== g)    begin n_bad++; $display("FAIL shift_gap: got %0d clocks want %0d", n, g); end
      n_cmp++; if (leds !== e) begin n_bad++; $display("FAIL shift_rot: got %h want %h", leds, e); end
    end
    switches = 8'hB0;
    exp_q.push_back(8'h02); gap_q.push_back(4);
    exp_q.push_back(8'h04); gap_q.push_back(5);
    exp_q.push_back(8'h08); gap_q.push_back(1);
    exp_q.push_back(8'h10); gap_q.push_back(1);
    exp_q.push_back(8'h20); gap_q.push_back(1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = gap_q.pop_front();
      wait_tick(g + 4, n);
      n_cmp++; if (n !== g)    begin n_bad++; $display("FAIL speed_gap: got %0d clocks want %0d", n, g); end
      n_cmp++; if (leds !== e) begin n_bad++; $display("FAIL speed_rot: got %h want %h", leds, e); end
    end
  endtask

  task automatic test_bounce();
    logic [7:0] e;
    int g, n;
    logic [7:0] seq [15];
    seq = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40,
            8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
    switches = 8'hC0;
    cycles(8);
    n_cmp++; if (leds !== 8'h01) begin n_bad++; $display("FAIL bounce_entry: got %h want 01", leds); end
    n_cmp++; if (mode !== 2'b11) begin n_bad++; $display("FAIL bounce_mode: got %b want 11", mode); end
    n_cmp++; if (tick !== 1'b0)  begin n_bad++; $display("FAIL bounce_entry_tick: got %b want 0", tick); end
    for (int i = 0; i < 15; i++) begin
      exp_q.push_back(seq[i]); gap_q.push_back(8);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = gap_q.pop_front();
      wait_tick(g + 4, n);
      n_cmp++; if (n !== g)    begin n_bad++; $display("FAIL bounce_gap: got %0d clocks want %0d", n, g); end
      n_cmp++; if (leds !== e) begin n_bad++; $display("FAIL bounce_pos: got %h want %h", leds, e); end
    end
  endtask

  task automatic test_reload();
    logic [7:0] e;
    int g, n;
    switches = 8'h40;
    cycles(8);
    n_cmp++; if (leds !== 8'h00) begin n_bad++; $display("FAIL reload_count_entry: got %h want 00", leds); end
    for (int i = 1; i <= 5; i++) begin
      exp_q.push_back(8'(i)); gap_q.push_back(8);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = gap_q.pop_front();
      wait_tick(g + 4, n);
      n_cmp++; if (n !== g)    begin n_bad++; $display("FAIL reload_count_gap: got %0d clocks want %0d", n, g); end
      n_cmp++; if (leds !== e) begin n_bad++; $display("FAIL reload_count: got %h want %h", leds, e); end
    end
    switches = 8'h80;
    cycles(7);
    n_cmp++; if (leds !== 8'h05) begin n_bad++; $display("FAIL reload_hold: got %h want 05", leds); end
    cycles(1);
    n_cmp++; if (leds !== 8'h01) begin n_bad++; $display("FAIL reload_load: got %h want 01", leds); end
    n_cmp++; if (tick !== 1'b0)  begin n_bad++; $display("FAIL reload_tick: got %b want 0", tick); end
    exp_q.push_back(8'h02); gap_q.push_back(8);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = gap_q.pop_front();
      wait_tick(g + 4, n);
      n_cmp++; if (n !== g)    begin n_bad++; $display("FAIL reload_first_gap: got %0d clocks want %0d", n, g); end
      n_cmp++; if (leds !== e) begin n_bad++; $display("FAIL reload_first_step: got %h want %h", leds, e); end
    end
    cycles(3);
    rst = 1'b0;
    cycles(1);
    n_cmp++; if (leds !== 8'h00) begin n_bad++; $display("FAIL midrun_reset_leds: got %h want 00", leds); end
    n_cmp++; if (mode !== 2'b00) begin n_bad++; $display("FAIL midrun_reset_mode: got %b want 00", mode); end
    n_cmp++; if (tick !== 1'b0)  begin n_bad++; $display("FAIL midrun_reset_tick: got %b want 0", tick); end
    rst = 1'b1;
    cycles(2);
  endtask

  initial begin
    test_reset();
    test_pass();
    test_count();
    test_shift();
    test_bounce();
    test_reload();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
